// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier/divider between NumReq
// requesters: latches the granted operands, drives the unit, buffers the result.
module ibex_multdiv_arbiter #(
    parameter int unsigned NumReq = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq-1:0][1:0]  req_op_i,
    input  logic [NumReq-1:0][1:0]  req_signed_i,
    input  logic [NumReq-1:0][31:0] req_op_a_i,
    input  logic [NumReq-1:0][31:0] req_op_b_i,
    input  logic [NumReq-1:0]       req_kill_i,
    output logic [NumReq-1:0]       rsp_valid_o,
    input  logic [NumReq-1:0]       rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic                    md_mult_en_o,
    output logic                    md_div_en_o,
    output logic                    md_mult_sel_o,
    output logic                    md_div_sel_o,
    output logic [1:0]              md_operator_o,
    output logic [1:0]              md_signed_mode_o,
    output logic [31:0]             md_op_a_o,
    output logic [31:0]             md_op_b_o,
    output logic                    md_ready_id_o,
    input  logic                    md_valid_i,
    input  logic [31:0]             md_result_i,
    output logic                    busy_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e          r_state;
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] r_owner;
    logic [1:0]      r_op;
    logic [1:0]      r_signed;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic [31:0]     r_result;

    logic [NumReq-1:0] w_mask_hi;
    logic [NumReq-1:0] w_valid_hi;
    logic [NumReq-1:0] w_pool;
    logic              w_found;
    logic [IdxW-1:0]   w_gnt_idx;
    logic [IdxW-1:0]   w_ptr_next;
    logic              w_active;
    logic              w_is_div;
    logic              w_owner_kill;
    logic              w_owner_take;

    function automatic logic [NumReq-1:0] idx_to_oh(input logic [IdxW-1:0] idx);
        logic [NumReq-1:0] oh;
        for (int j = 0; j < NumReq; j++) begin
            oh[j] = (idx == IdxW'(j));
        end
        return oh;
    endfunction

    // Round-robin pick: lowest valid index at or above the pointer, otherwise wrap to the lowest.
    always_comb begin
        w_mask_hi = '0;
        w_gnt_idx = '0;
        for (int j = 0; j < NumReq; j++) begin
            w_mask_hi[j] = (IdxW'(j) >= r_ptr);
        end
        w_valid_hi = req_valid_i & w_mask_hi;
        w_pool     = (|w_valid_hi) ? w_valid_hi : req_valid_i;
        for (int j = NumReq - 1; j >= 0; j--) begin
            w_gnt_idx = w_pool[j] ? IdxW'(j) : w_gnt_idx;
        end
    end

    assign w_found      = |req_valid_i;
    assign w_ptr_next   = (w_gnt_idx == IdxW'(NumReq - 1)) ? '0 : w_gnt_idx + IdxW'(1'b1);
    assign w_active     = (r_state == S_BUSY) || (r_state == S_DRAIN);
    assign w_is_div     = r_op[1];
    assign w_owner_kill = req_kill_i[r_owner];
    assign w_owner_take = rsp_ready_i[r_owner];

    // Control FSM with operand/result latches; a kill coinciding with md_valid_i discards the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_op     <= 2'b00;
            r_signed <= 2'b00;
            r_op_a   <= 32'h0000_0000;
            r_op_b   <= 32'h0000_0000;
            r_result <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner  <= w_gnt_idx;
                        r_op     <= req_op_i[w_gnt_idx];
                        r_signed <= req_signed_i[w_gnt_idx];
                        r_op_a   <= req_op_a_i[w_gnt_idx];
                        r_op_b   <= req_op_b_i[w_gnt_idx];
                        r_ptr    <= w_ptr_next;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_owner_kill) begin
                        r_state <= md_valid_i ? S_IDLE : S_DRAIN;
                    end else if (md_valid_i) begin
                        r_result <= md_result_i;
                        r_state  <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (md_valid_i) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (w_owner_take || w_owner_kill) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Reset gates the grant so nothing is accepted while the block is being cleared.
    assign req_ready_o = (r_state == S_IDLE && !rst_i && w_found) ? idx_to_oh(w_gnt_idx) : '0;
    assign rsp_valid_o = (r_state == S_RESP) ? idx_to_oh(r_owner) : '0;
    assign rsp_data_o  = r_result;
    assign busy_o      = (r_state != S_IDLE);

    // Unit sees zeros outside BUSY/DRAIN so it parks in its idle state.
    assign md_mult_en_o     = w_active & ~w_is_div;
    assign md_mult_sel_o    = w_active & ~w_is_div;
    assign md_div_en_o      = w_active & w_is_div;
    assign md_div_sel_o     = w_active & w_is_div;
    assign md_ready_id_o    = w_active;
    assign md_operator_o    = w_active ? r_op : 2'b00;
    assign md_signed_mode_o = w_active ? r_signed : 2'b00;
    assign md_op_a_o        = w_active ? r_op_a : 32'h0000_0000;
    assign md_op_b_o        = w_active ? r_op_b : 32'h0000_0000;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Self-checking bench: randomized and directed requesters against a transaction-level
// model of the arbiter, with the bench itself acting as the iterative mult/div unit.
module tb_ibex_multdiv_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_i;
    logic [N-1:0]        req_valid_i, req_ready_o, req_kill_i, rsp_valid_o, rsp_ready_i;
    logic [N-1:0][1:0]   req_op_i, req_signed_i;
    logic [N-1:0][31:0]  req_op_a_i, req_op_b_i;
    logic [31:0]         rsp_data_o, md_op_a_o, md_op_b_o, md_result_i;
    logic                md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
    logic                md_ready_id_o, md_valid_i, busy_o;
    logic [1:0]          md_operator_o, md_signed_mode_o;

    ibex_multdiv_arbiter #(.NumReq(N)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_signed_i(req_signed_i),
        .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
        .req_kill_i(req_kill_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
        .md_mult_sel_o(md_mult_sel_o), .md_div_sel_o(md_div_sel_o),
        .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
        .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o), .md_ready_id_o(md_ready_id_o),
        .md_valid_i(md_valid_i), .md_result_i(md_result_i), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Requests each requester is currently presenting
    logic        p_v  [N];
    logic [1:0]  p_op [N];
    logic [1:0]  p_sm [N];
    logic [31:0] p_a  [N];
    logic [31:0] p_b  [N];

    // Outstanding-transaction model: phase 0 executing, 1 killed/draining, 2 awaiting pickup
    bit          m_has;
    int          m_owner, m_ph, m_ptr;
    logic [1:0]  m_op, m_sm;
    logic [31:0] m_a, m_b, m_exp, m_rdata;

    // Bench-side mult/div unit
    bit          u_run;
    int          u_cnt;
    int          u_maxlat = 4;
    logic [31:0] u_res;

    bit          rand_mode  = 1'b0;
    bit          repost_mul = 1'b0;
    logic [31:0] last_rsp;
    int          last_owner;
    int          rsp_count [N];
    int          grants [$];

    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [1:0] sm,
                                           input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa, sb;
        logic signed [65:0] p;
        sa = $signed({sm[0] & a[31], a});
        sb = $signed({sm[1] & b[31], b});
        p  = sa * sb;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sm == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    return 32'($signed(a) / $signed(b));
                end
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (sm == 2'b11) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                    return 32'($signed(a) % $signed(b));
                end
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    function automatic void set_req(input int i, input logic [1:0] op, input logic [1:0] sm,
                                    input logic [31:0] a, input logic [31:0] b);
        p_v[i] = 1'b1; p_op[i] = op; p_sm[i] = sm; p_a[i] = a; p_b[i] = b;
    endfunction

    function automatic void gen_req(input int i);
        logic [1:0] op;
        logic       s;
        op = 2'($urandom);
        s  = 1'($urandom);
        set_req(i, op, op[1] ? {s, s} : 2'($urandom), pick_val(), pick_val());
    endfunction

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (p_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply_ports();
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = p_v[i];
            req_op_i[i]     = p_v[i] ? p_op[i] : 2'($urandom);
            req_signed_i[i] = p_v[i] ? p_sm[i] : 2'($urandom);
            req_op_a_i[i]   = p_v[i] ? p_a[i]  : $urandom;
            req_op_b_i[i]   = p_v[i] ? p_b[i]  : $urandom;
        end
    endtask

    task automatic post(input int i, input logic [1:0] op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b);
        set_req(i, op, sm, a, b);
        apply_ports();
    endtask

    // Runs just after each rising edge: new stimulus and the unit's result pulse
    task automatic drive();
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!p_v[i] && $urandom_range(0, 3) == 0) gen_req(i);
                req_kill_i[i] = ($urandom_range(0, 15) == 0);
            end
            rsp_ready_i = N'($urandom);
        end
        apply_ports();
        md_valid_i  = 1'b0;
        md_result_i = $urandom;
        if (u_run) begin
            u_cnt--;
            if (u_cnt == 0) begin
                md_valid_i  = 1'b1;
                md_result_i = u_res;
                u_run       = 1'b0;
            end
        end
    endtask

    // Mid-cycle: compare outputs with the model, then advance the model to the next edge
    task automatic observe();
        int         g;
        int         r;
        logic [N-1:0] exp_ready, exp_rsp;
        bit         act;
        g = -1;
        if (!m_has && !rst_i) begin
            for (int k = 0; k < N; k++) begin
                r = (m_ptr + k) % N;
                if (g < 0 && req_valid_i[r]) g = r;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_rsp = '0;
        if (m_has && m_ph == 2) exp_rsp[m_owner] = 1'b1;
        act = m_has && (m_ph != 2);

        check_eq("busy", 32'(busy_o), 32'(m_has));
        check_eq("req_ready", 32'(req_ready_o), 32'(exp_ready));
        check_eq("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp));
        check_eq("rsp_data", rsp_data_o, m_rdata);
        check_eq("md_en_sel",
                 32'({md_mult_en_o, md_mult_sel_o, md_div_en_o, md_div_sel_o, md_ready_id_o}),
                 32'(act ? (m_op[1] ? 5'b00111 : 5'b11001) : 5'b00000));
        check_eq("md_ctrl", 32'({md_operator_o, md_signed_mode_o}), 32'(act ? {m_op, m_sm} : 4'b0000));
        check_eq("md_op_a", md_op_a_o, act ? m_a : 32'h0);
        check_eq("md_op_b", md_op_b_o, act ? m_b : 32'h0);

        if (rst_i) begin
            m_has = 1'b0; m_ptr = 0; m_rdata = 32'h0; u_run = 1'b0;
            return;
        end
        if ((md_mult_en_o || md_div_en_o) && !u_run && !md_valid_i) begin
            u_run = 1'b1;
            u_cnt = $urandom_range(1, u_maxlat);
            u_res = ref_md(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
        end
        if (!m_has) begin
            if (g >= 0) begin
                m_has = 1'b1; m_owner = g; m_ph = 0;
                m_op = p_op[g]; m_sm = p_sm[g]; m_a = p_a[g]; m_b = p_b[g];
                m_exp = ref_md(m_op, m_sm, m_a, m_b);
                m_ptr = (g + 1) % N;
                p_v[g] = 1'b0;
                grants.push_back(g);
                if (repost_mul) set_req(g, 2'd0, 2'b00, $urandom, $urandom);
            end
        end else begin
            case (m_ph)
                0: begin
                    if (req_kill_i[m_owner]) begin
                        if (md_valid_i) m_has = 1'b0;
                        else m_ph = 1;
                    end else if (md_valid_i) begin
                        m_ph = 2;
                        m_rdata = m_exp;
                    end
                end
                1: if (md_valid_i) m_has = 1'b0;
                default: begin
                    if (rsp_ready_i[m_owner] || req_kill_i[m_owner]) begin
                        if (!req_kill_i[m_owner]) begin
                            last_rsp = rsp_data_o;
                            last_owner = m_owner;
                            rsp_count[m_owner]++;
                        end
                        m_has = 1'b0;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        #4;
        observe();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic wait_done(input int maxc);
        int c;
        c = 0;
        while ((m_has || any_pending() || busy_o) && c < maxc) begin
            cycle();
            c++;
        end
        check_eq("done_timeout", 32'(busy_o), 32'd0);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < N; i++) begin
            p_v[i] = 1'b0; p_op[i] = 2'b00; p_sm[i] = 2'b00; p_a[i] = 32'h0; p_b[i] = 32'h0;
            rsp_count[i] = 0;
        end
        m_has = 1'b0; m_ptr = 0; m_rdata = 32'h0; m_owner = 0; m_ph = 0;
        m_op = 2'b00; m_sm = 2'b00; m_a = 32'h0; m_b = 32'h0; m_exp = 32'h0;
        u_run = 1'b0; u_cnt = 0; u_res = 32'h0; last_rsp = 32'h0; last_owner = -1;
        rst_i = 1'b1; req_kill_i = '0; rsp_ready_i = '0;
        md_valid_i = 1'b0; md_result_i = 32'h0;
        apply_ports();
        repeat (3) @(posedge clk);
        #1;
        // A request during reset must not be accepted
        post(1, 2'd0, 2'b00, 32'd1, 32'd1);
        cycle();
        p_v[1] = 1'b0;
        rst_i  = 1'b0;
        apply_ports();
        cycle();
        cycle();

        // MULL 3*5 from requester 0
        rsp_ready_i = '1;
        post(0, 2'd0, 2'b00, 32'd3, 32'd5);
        wait_done(50);
        check_eq("t1_mull", last_rsp, 32'd15);
        check_eq("t1_owner", 32'(last_owner), 32'd0);

        // Signed DIV / REM / divide by zero from requester 1
        post(1, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(50);
        check_eq("t2_div", last_rsp, 32'hFFFF_FFFD);
        post(1, 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(50);
        check_eq("t2_rem", last_rsp, 32'hFFFF_FFFF);
        post(1, 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd0);
        wait_done(50);
        check_eq("t2_div0", last_rsp, 32'hFFFF_FFFF);

        // Both requesters always valid: grants must alternate
        grants.delete();
        repost_mul = 1'b1;
        post(0, 2'd0, 2'b00, 32'd2, 32'd3);
        post(1, 2'd0, 2'b00, 32'd4, 32'd5);
        repeat (60) cycle();
        repost_mul = 1'b0;
        for (int i = 0; i < N; i++) p_v[i] = 1'b0;
        apply_ports();
        wait_done(50);
        check_eq("t3_ngrants", 32'(grants.size() >= 6), 32'd1);
        for (int i = 1; i < grants.size(); i++)
            check_eq("t3_alternate", 32'(grants[i]), 32'((grants[i-1] + 1) % N));

        // MULH with operand inputs scrambled after acceptance
        post(0, 2'd1, 2'b11, 32'h8000_0000, 32'h8000_0000);
        wait_done(50);
        check_eq("t4_mulh", last_rsp, 32'h4000_0000);

        // Kill the owner mid-DIV; requester 1 is served next
        post(1, 2'd0, 2'b00, 32'd2, 32'd2);
        wait_done(50);
        u_maxlat = 6;
        post(0, 2'd2, 2'b00, 32'd100, 32'd7);
        post(1, 2'd0, 2'b00, 32'd6, 32'd7);
        cycle();
        n0 = rsp_count[0];
        req_kill_i = 2'b01;
        cycle();
        req_kill_i = '0;
        wait_done(100);
        check_eq("t5_no_rsp0", 32'(rsp_count[0]), 32'(n0));
        check_eq("t5_next_grant", 32'(grants[$]), 32'd1);
        check_eq("t5_rsp1", last_rsp, 32'd42);
        u_maxlat = 4;

        // Response held back: no new grant, response stable
        rsp_ready_i = '0;
        post(0, 2'd0, 2'b00, 32'd9, 32'd9);
        post(1, 2'd0, 2'b00, 32'd3, 32'd3);
        repeat (15) cycle();
        check_eq("t6_hold_valid", 32'(rsp_valid_o), 32'd1);
        check_eq("t6_hold_data", rsp_data_o, 32'd81);
        rsp_ready_i = '1;
        wait_done(60);
        check_eq("t6_last", last_rsp, 32'd9);

        // Reset while BUSY
        u_maxlat = 8;
        post(0, 2'd2, 2'b00, 32'd50, 32'd5);
        cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        cycle();
        check_eq("t7_busy", 32'(busy_o), 32'd0);
        check_eq("t7_div_en", 32'(md_div_en_o), 32'd0);
        check_eq("t7_rdata", rsp_data_o, 32'd0);
        u_maxlat = 4;

        // Randomized traffic with random kills and back-pressure
        rand_mode = 1'b1;
        repeat (3000) cycle();
        rand_mode = 1'b0;
        req_kill_i = '0;
        rsp_ready_i = '1;
        for (int i = 0; i < N; i++) p_v[i] = 1'b0;
        apply_ports();
        wait_done(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_multdiv_arbiter.md
Name: ibex_multdiv_arbiter

Overview:
- Shares one slow multiplier/divider unit between NumReq requesters, e.g. the core ID stage and a coprocessor or debug-side user.
- Accepts requests with a valid/ready handshake and arbitrates round-robin.
- Latches operands so they stay stable for the whole iterative operation, then sequences the unit's enable/select/ready_id handshake.
- Holds each result in a response buffer until the owning requester takes it.

Parameters:
NumReq, 2, number of requesters (2..4); index width IdxW = $clog2(NumReq).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NumReq  request valid per requester
req_ready_o  out  NumReq  request accepted (one-hot or zero)
req_op_i  in  NumReq x 2  md_op: 0 MULL, 1 MULH, 2 DIV, 3 REM
req_signed_i  in  NumReq x 2  signed_mode per requester
req_op_a_i  in  NumReq x 32  operand A
req_op_b_i  in  NumReq x 32  operand B
req_kill_i  in  NumReq  discard the requester's outstanding op
rsp_valid_o  out  NumReq  result valid (one-hot or zero)
rsp_ready_i  in  NumReq  result taken
rsp_data_o  out  32  result, shared by all requesters
md_mult_en_o / md_div_en_o  out  1 each  unit dynamic enables
md_mult_sel_o / md_div_sel_o  out  1 each  unit static selects
md_operator_o  out  2  latched op
md_signed_mode_o  out  2  latched signed_mode
md_op_a_o / md_op_b_o  out  32 each  latched operands
md_ready_id_o  out  1  unit ready_id
md_valid_i  in  1  unit result valid
md_result_i  in  32  unit result
busy_o  out  1  state != IDLE

Behaviour:
- State machine: IDLE, BUSY, DRAIN, RESP.
- Reset: state IDLE, priority pointer 0, owner 0, latched op/operands/result 0. All outputs are 0 during and after reset until a request arrives.

IDLE:
- Search from the priority pointer upward (modulo NumReq) for the first requester with req_valid_i=1. Raise that requester's req_ready_o combinationally in the same cycle.
- On handshake, latch owner, op, signed, op_a and op_b, set the priority pointer to (owner+1) mod NumReq, and go to BUSY.
- No valid request: stay in IDLE, pointer unchanged.
- req_ready_o is 0 in every other state.

BUSY and DRAIN, unit drive:
- md_mult_sel_o = md_mult_en_o = (op is MULL or MULH).
- md_div_sel_o = md_div_en_o = (op is DIV or REM).
- md_ready_id_o = 1.
- All md_* outputs are 0 in IDLE and RESP, so the unit parks in its idle state.

BUSY:
- If md_valid_i=1, capture md_result_i into the result register and go to RESP.
- If req_kill_i[owner]=1 (and md_valid_i=0), go to DRAIN.
- md_valid_i and kill in the same cycle: kill wins; result is discarded and the next state is IDLE.

DRAIN:
- The unit cannot be aborted safely, so it keeps running to completion.
- On md_valid_i=1, discard the result and go to IDLE. No rsp_valid_o is raised for the killed op.

RESP:
- rsp_valid_o[owner]=1 and rsp_data_o = result register.
- On rsp_ready_i[owner]=1, go to IDLE.
- req_kill_i[owner] in RESP drops the response and goes to IDLE.
- rsp_data_o holds its last value outside RESP.

Latency and ordering:
- rsp_valid_o rises exactly 1 cycle after the md_valid_i pulse.
- From RESP, the next grant happens no earlier than 1 cycle after the response handshake (IDLE cycle).
- Only one op is outstanding at a time. Kills of non-owners are ignored.

Stability:
- Latched operands and op are stable from the first BUSY cycle until leaving BUSY/DRAIN, regardless of the req_* inputs.

Synchronous reset mid-operation:
- Returns to IDLE next cycle and drops all enables. The unit must be reset by the same reset domain.

Test Plan:
- Requester 0 MULL op_a=3, op_b=5, rsp_ready_i=1 -> req_ready_o[0] asserted in the valid cycle; rsp_data_o=15 with rsp_valid_o[0] exactly 1 cycle after md_valid_i; busy_o low again afterwards.
- Requester 1 DIV signed=2'b11, op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD. Same operands with REM -> 0xFFFFFFFF. DIV with op_b=0 -> 0xFFFFFFFF.
- Both requesters valid every cycle with back-to-back MULLs -> grants alternate 0,1,0,1; no requester is granted twice consecutively while the other is waiting.
- Requester 0 MULH 0x80000000*0x80000000 with signed=2'b11; change req_op_a_i and req_op_b_i every cycle after acceptance -> result 0x40000000 (latched operands used).
- Kill owner mid-DIV -> no rsp_valid_o; md_*_en stays high until md_valid_i; then IDLE, and requester 1's pending request is granted next.
- Hold rsp_ready_i=0 for 10 cycles -> rsp_valid_o and rsp_data_o stable, no new grants. Assert rst_i while in BUSY -> next cycle all outputs 0 and state IDLE.
